// File: rtl/dataram_pkg.sv
// Shared definitions for the internal data RAM controller: access mode
// encodings, controller state enum, default bit-region geometry and the
// even-parity helper used when DATARAM_PARITY_EN is defined.
package dataram_pkg;

  localparam logic [1:0] MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MODE_BIT      = 2'b01;
  localparam logic [1:0] MODE_RN       = 2'b10;
  localparam logic [1:0] MODE_INDIRECT = 2'b11;

  localparam logic [7:0] BIT_BASE_DEF  = 8'h20;
  localparam int         BIT_BYTES_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MOD,
    S_WR,
    S_RESP
  } state_t;

  // Even parity: the returned bit makes the 9-bit word have an even number of ones.
  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/dataram_array.sv
// Single-port synchronous byte array: one write enable, registered read,
// no reset on contents or read register.
module dataram_array #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port and registered read port share the one address.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dataram_ctrl.sv
// Internal data RAM controller: direct / bit / Rn / indirect access to a
// single-port byte array behind a req/ack handshake. Bit writes are done as
// read-modify-write. Optional feature macro: DATARAM_PARITY_EN (9-bit array
// with even parity, parity errors reported on err).
module dataram_ctrl
  import dataram_pkg::*;
#(
  parameter int         DEPTH     = 256,
  parameter logic [7:0] BIT_BASE  = BIT_BASE_DEF,
  parameter int         BIT_BYTES = BIT_BYTES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] mode,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [1:0] bank,
  input  logic [7:0] din,
  input  logic       bin,
  output logic       ack,
  output logic       busy,
  output logic [7:0] dout,
  output logic       bout,
  output logic       err
);

  localparam int AW = $clog2(DEPTH);
`ifdef DATARAM_PARITY_EN
  localparam int W = 9;
`else
  localparam int W = 8;
`endif

  state_t     r_state, w_next;

  // Request latched at acceptance
  logic [1:0] r_mode;
  logic       r_we;
  logic [7:0] r_ea;
  logic [2:0] r_bidx;
  logic [7:0] r_din;
  logic       r_bin;
  logic       r_ill;
  logic       r_bytewr;

  // Response holding registers
  logic [7:0] r_dout;
  logic       r_bout;
  logic       r_err;

  logic [7:0]   w_ea;
  logic         w_ill;
  logic         w_bytewr;
  logic [W-1:0] w_rdata;
  logic [W-1:0] w_wdata;
  logic [7:0]   w_wbyte;
  logic [7:0]   w_mod;
  logic         w_perr;
  logic         w_arr_we;
  logic         w_arr_re;
  logic         w_bitwr;
  logic [7:0]   w_dout_rsp;
  logic         w_bout_rsp;
  logic         w_err_rsp;
  logic         w_unused_ea;

  // Effective address and legality decode of the incoming request
  always_comb begin
    w_ea  = addr;
    w_ill = 1'b0;
    unique case (mode)
      MODE_DIRECT: w_ill = addr[7];
      MODE_BIT: begin
        w_ea  = BIT_BASE + {4'b0000, addr[6:3]};
        w_ill = ({1'b0, addr} >= 9'(8 * BIT_BYTES));
      end
      MODE_RN:     w_ea = {3'b000, bank, addr[2:0]};
      default:     w_ill = ({1'b0, addr} >= 9'(DEPTH));
    endcase
  end

  assign w_bytewr = we && (mode != MODE_BIT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; errored requests go straight to the response
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (req) w_next = w_ill ? S_RESP : (w_bytewr ? S_WR : S_RD);
      S_RD:   w_next = w_bitwr ? S_MOD : S_RESP;
      S_MOD:  w_next = S_RESP;
      S_WR:   w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  // Capture the request when it is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode   <= MODE_DIRECT;
      r_we     <= 1'b0;
      r_ea     <= 8'h00;
      r_bidx   <= 3'd0;
      r_din    <= 8'h00;
      r_bin    <= 1'b0;
      r_ill    <= 1'b0;
      r_bytewr <= 1'b0;
    end else if (r_state == S_IDLE && req) begin
      r_mode   <= mode;
      r_we     <= we;
      r_ea     <= w_ea;
      r_bidx   <= addr[2:0];
      r_din    <= din;
      r_bin    <= bin;
      r_ill    <= w_ill;
      r_bytewr <= w_bytewr;
    end
  end

  // Legal accesses never reach beyond DEPTH, so ea[7] is dead when DEPTH=128.
  assign w_unused_ea = r_ea[7];
  assign w_bitwr     = (r_mode == MODE_BIT) && r_we;

  // Read byte with the addressed bit replaced by the write bit
  always_comb begin
    w_mod         = w_rdata[7:0];
    w_mod[r_bidx] = r_bin;
  end

`ifdef DATARAM_PARITY_EN
  assign w_perr  = (w_rdata[8] != parity8(w_rdata[7:0]));
  assign w_wdata = {parity8(w_wbyte), w_wbyte};
`else
  assign w_perr  = 1'b0;
  assign w_wdata = w_wbyte;
`endif

  // A corrupted byte is never written back by a bit write.
  assign w_wbyte  = (r_state == S_WR) ? r_din : w_mod;
  assign w_arr_we = (r_state == S_WR) || ((r_state == S_MOD) && !w_perr);
  assign w_arr_re = (r_state == S_RD);

  dataram_array #(
    .DEPTH(DEPTH),
    .WIDTH(W),
    .AW   (AW)
  ) u_array (
    .clk    (clk),
    .i_we   (w_arr_we),
    .i_re   (w_arr_re),
    .i_addr (r_ea[AW-1:0]),
    .i_wdata(w_wdata),
    .o_rdata(w_rdata)
  );

  // Response values presented during RESP; errors keep the previous data
  always_comb begin
    w_dout_rsp = r_dout;
    w_bout_rsp = r_bout;
    w_err_rsp  = r_ill || (!r_bytewr && w_perr);
    if (!r_ill) begin
      if (r_bytewr) begin
        w_dout_rsp = r_din;
      end else if (w_bitwr && !w_perr) begin
        w_dout_rsp = w_mod;
        w_bout_rsp = r_bin;
      end else begin
        w_dout_rsp = w_rdata[7:0];
        if (r_mode == MODE_BIT) w_bout_rsp = w_rdata[r_bidx];
      end
    end
  end

  // Hold the last response between accesses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= 8'h00;
      r_bout <= 1'b0;
      r_err  <= 1'b0;
    end else if (r_state == S_RESP) begin
      r_dout <= w_dout_rsp;
      r_bout <= w_bout_rsp;
      r_err  <= w_err_rsp;
    end
  end

  assign ack  = (r_state == S_RESP);
  assign busy = (r_state != S_IDLE);
  assign dout = ack ? w_dout_rsp : r_dout;
  assign bout = ack ? w_bout_rsp : r_bout;
  assign err  = ack ? w_err_rsp  : r_err;

endmodule

// File: tb/tb_dataram_ctrl.sv
// Directed bench for dataram_ctrl (DEPTH=128 so the indirect limit is live).
module tb_dataram_ctrl;
  import dataram_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       we = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [1:0] bank = 2'b00;
  logic [7:0] din = 8'h00;
  logic       bin = 1'b0;
  logic       ack, busy, bout, err;
  logic [7:0] dout;

  int n_vec = 0;
  int n_err = 0;

  dataram_ctrl #(.DEPTH(128), .BIT_BASE(8'h20), .BIT_BYTES(16)) u_dut (
    .clk(clk), .rst(rst), .req(req), .mode(mode), .we(we), .addr(addr),
    .bank(bank), .din(din), .bin(bin), .ack(ack), .busy(busy),
    .dout(dout), .bout(bout), .err(err)
  );

  always #5 clk = ~clk;

  // One handshake; lat = cycles from sampling edge to ack (0 = timeout).
  task automatic access(input logic [1:0] m, input logic w, input logic [7:0] a,
                        input logic [1:0] bk, input logic [7:0] d, input logic b,
                        output int lat, output logic [7:0] od, output logic ob,
                        output logic oe);
    @(negedge clk);
    mode = m; we = w; addr = a; bank = bk; din = d; bin = b; req = 1'b1;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (ack) begin lat = c; break; end
    end
    od = dout; ob = bout; oe = err;
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if ({ack, busy, err, bout} !== 4'b0000) begin
      $display("FAIL reset_ctl got %b want 0000", {ack, busy, err, bout}); n_err++; end
    n_vec++; if (dout !== 8'h00) begin
      $display("FAIL reset_dout got %h want 00", dout); n_err++; end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_byte_roundtrip();
    int lat; logic [7:0] d; logic b, e;
    access(MODE_DIRECT, 1'b1, 8'h30, 2'b00, 8'hA5, 1'b0, lat, d, b, e);
    n_vec++; if (lat !== 2 || d !== 8'hA5 || e !== 1'b0) begin
      $display("FAIL byte_wr lat=%0d dout=%h err=%b want 2/a5/0", lat, d, e); n_err++; end
    access(MODE_DIRECT, 1'b0, 8'h30, 2'b00, 8'h00, 1'b0, lat, d, b, e);
    n_vec++; if (lat !== 2 || d !== 8'hA5 || e !== 1'b0) begin
      $display("FAIL byte_rd lat=%0d dout=%h err=%b want 2/a5/0", lat, d, e); n_err++; end
    n_vec++; if (ack !== 1'b0 || busy !== 1'b0 || dout !== 8'hA5) begin
      $display("FAIL ack_pulse ack=%b busy=%b dout=%h want 0/0/a5", ack, busy, dout); n_err++; end
    // Indirect at the top legal address
    access(MODE_INDIRECT, 1'b1, 8'h7F, 2'b00, 8'hC3, 1'b0, lat, d, b, e);
    access(MODE_INDIRECT, 1'b0, 8'h7F, 2'b00, 8'h00, 1'b0, lat, d, b, e);
    n_vec++; if (lat !== 2 || d !== 8'hC3 || e !== 1'b0) begin
      $display("FAIL ind_7f lat=%0d dout=%h err=%b want 2/c3/0", lat, d, e); n_err++; end
  endtask

  task automatic test_bank();
    int lat; logic [7:0] d; logic b, e;
    access(MODE_DIRECT, 1'b1, 8'h03, 2'b00, 8'h33, 1'b0, lat, d, b, e);
    access(MODE_RN, 1'b1, 8'h03, 2'b10, 8'h5C, 1'b0, lat, d, b, e);
    n_vec++; if (lat !== 2 || e !== 1'b0) begin
      $display("FAIL rn_wr lat=%0d err=%b want 2/0", lat, e); n_err++; end
    access(MODE_INDIRECT, 1'b0, 8'h13, 2'b00, 8'h00, 1'b0, lat, d, b, e);
    n_vec++; if (d !== 8'h5C) begin
      $display("FAIL rn_ind13 got %h want 5c", d); n_err++; end
    access(MODE_RN, 1'b0, 8'h03, 2'b00, 8'h00, 1'b0, lat, d, b, e);
    n_vec++; if (d !== 8'h33) begin
      $display("FAIL rn_bank0 got %h want 33", d); n_err++; end
    access(MODE_RN, 1'b0, 8'hFB, 2'b10, 8'h00, 1'b0, lat, d, b, e);
    n_vec++; if (d !== 8'h5C || e !== 1'b0) begin
      $display("FAIL rn_hi_ign dout=%h err=%b want 5c/0", d, e); n_err++; end
  endtask

  task automatic test_bit_rmw();
    int lat; logic [7:0] d; logic b, e;
    access(MODE_DIRECT, 1'b1, 8'h24, 2'b00, 8'h00, 1'b0, lat, d, b, e);
    access(MODE_BIT, 1'b1, 8'h25, 2'b00, 8'h00, 1'b1, lat, d, b, e);
    n_vec++; if (lat !== 3 || d !== 8'h20 || b !== 1'b1 || e !== 1'b0) begin
      $display("FAIL bit_wr lat=%0d dout=%h bout=%b err=%b want 3/20/1/0", lat, d, b, e); n_err++; end
    access(MODE_BIT, 1'b0, 8'h25, 2'b00, 8'h00, 1'b0, lat, d, b, e);
    n_vec++; if (lat !== 2 || b !== 1'b1 || d !== 8'h20) begin
      $display("FAIL bit_rd lat=%0d bout=%b dout=%h want 2/1/20", lat, b, d); n_err++; end
    access(MODE_BIT, 1'b0, 8'h24, 2'b00, 8'h00, 1'b0, lat, d, b, e);
    n_vec++; if (b !== 1'b0) begin
      $display("FAIL bit_rd0 got %b want 0", b); n_err++; end
    access(MODE_DIRECT, 1'b0, 8'h24, 2'b00, 8'h00, 1'b0, lat, d, b, e);
    n_vec++; if (d !== 8'h20) begin
      $display("FAIL bit_byte got %h want 20", d); n_err++; end
    // Top legal bit address 0x7F -> byte 0x2F bit 7
    access(MODE_DIRECT, 1'b1, 8'h2F, 2'b00, 8'h0F, 1'b0, lat, d, b, e);
    access(MODE_BIT, 1'b1, 8'h7F, 2'b00, 8'h00, 1'b1, lat, d, b, e);
    n_vec++; if (d !== 8'h8F || e !== 1'b0) begin
      $display("FAIL bit_7f dout=%h err=%b want 8f/0", d, e); n_err++; end
  endtask

  task automatic test_back_to_back();
    int lat; logic [7:0] d; logic b, e;
    access(MODE_BIT, 1'b1, 8'h25, 2'b00, 8'h00, 1'b0, lat, d, b, e);
    n_vec++; if (d !== 8'h00 || b !== 1'b0) begin
      $display("FAIL b2b_wr dout=%h bout=%b want 00/0", d, b); n_err++; end
    access(MODE_BIT, 1'b0, 8'h25, 2'b00, 8'h00, 1'b0, lat, d, b, e);
    n_vec++; if (b !== 1'b0 || d !== 8'h00) begin
      $display("FAIL b2b_rd bout=%b dout=%h want 0/00", b, d); n_err++; end
  endtask

  task automatic test_illegal();
    int lat; logic [7:0] d; logic b, e;
    access(MODE_DIRECT, 1'b1, 8'h10, 2'b00, 8'h77, 1'b0, lat, d, b, e);
    access(MODE_DIRECT, 1'b1, 8'h00, 2'b00, 8'h44, 1'b0, lat, d, b, e);
    access(MODE_DIRECT, 1'b1, 8'h20, 2'b00, 8'h00, 1'b0, lat, d, b, e);
    access(MODE_DIRECT, 1'b0, 8'h10, 2'b00, 8'h00, 1'b0, lat, d, b, e);
    access(MODE_DIRECT, 1'b1, 8'h90, 2'b00, 8'h11, 1'b0, lat, d, b, e);
    n_vec++; if (lat !== 1 || e !== 1'b1 || d !== 8'h77) begin
      $display("FAIL ill_dir lat=%0d err=%b dout=%h want 1/1/77", lat, e, d); n_err++; end
    n_vec++; if (err !== 1'b1) begin
      $display("FAIL err_hold got %b want 1", err); n_err++; end
    access(MODE_INDIRECT, 1'b0, 8'h80, 2'b00, 8'h00, 1'b0, lat, d, b, e);
    n_vec++; if (lat !== 1 || e !== 1'b1 || d !== 8'h77) begin
      $display("FAIL ill_ind_rd lat=%0d err=%b dout=%h want 1/1/77", lat, e, d); n_err++; end
    access(MODE_INDIRECT, 1'b1, 8'h80, 2'b00, 8'h22, 1'b0, lat, d, b, e);
    n_vec++; if (lat !== 1 || e !== 1'b1) begin
      $display("FAIL ill_ind_wr lat=%0d err=%b want 1/1", lat, e); n_err++; end
    access(MODE_BIT, 1'b1, 8'h80, 2'b00, 8'h00, 1'b1, lat, d, b, e);
    n_vec++; if (lat !== 1 || e !== 1'b1) begin
      $display("FAIL ill_bit lat=%0d err=%b want 1/1", lat, e); n_err++; end
    access(MODE_DIRECT, 1'b0, 8'h10, 2'b00, 8'h00, 1'b0, lat, d, b, e);
    n_vec++; if (d !== 8'h77 || e !== 1'b0) begin
      $display("FAIL ill_keep10 dout=%h err=%b want 77/0", d, e); n_err++; end
    access(MODE_DIRECT, 1'b0, 8'h00, 2'b00, 8'h00, 1'b0, lat, d, b, e);
    n_vec++; if (d !== 8'h44) begin
      $display("FAIL ill_keep00 got %h want 44", d); n_err++; end
    access(MODE_DIRECT, 1'b0, 8'h20, 2'b00, 8'h00, 1'b0, lat, d, b, e);
    n_vec++; if (d !== 8'h00) begin
      $display("FAIL ill_keep20 got %h want 00", d); n_err++; end
  endtask

  task automatic test_reset_midop();
    int lat; logic [7:0] d; logic b, e;
    access(MODE_DIRECT, 1'b1, 8'h20, 2'b00, 8'h5A, 1'b0, lat, d, b, e);
    @(negedge clk);
    mode = MODE_BIT; we = 1'b1; addr = 8'h00; bin = 1'b1; req = 1'b1;
    @(posedge clk); #1;   // read cycle
    @(posedge clk); #1;   // bit-merge cycle
    n_vec++; if (busy !== 1'b1 || ack !== 1'b0) begin
      $display("FAIL midop_busy busy=%b ack=%b want 1/0", busy, ack); n_err++; end
    rst = 1'b1; req = 1'b0;
    #1;
    n_vec++; if ({ack, busy, err, bout} !== 4'b0000 || dout !== 8'h00) begin
      $display("FAIL midop_rst ctl=%b dout=%h want 0000/00", {ack, busy, err, bout}, dout); n_err++; end
    @(negedge clk); rst = 1'b0;
    access(MODE_DIRECT, 1'b0, 8'h20, 2'b00, 8'h00, 1'b0, lat, d, b, e);
    n_vec++; if (d !== 8'h5A || lat !== 2) begin
      $display("FAIL midop_mem dout=%h lat=%0d want 5a/2", d, lat); n_err++; end
  endtask

`ifdef DATARAM_PARITY_EN
  task automatic test_parity();
    int lat; logic [7:0] d; logic b, e;
    access(MODE_DIRECT, 1'b1, 8'h40, 2'b00, 8'h0F, 1'b0, lat, d, b, e);
    u_dut.u_array.r_mem[7'h40] = u_dut.u_array.r_mem[7'h40] ^ 9'h001;
    access(MODE_DIRECT, 1'b0, 8'h40, 2'b00, 8'h00, 1'b0, lat, d, b, e);
    n_vec++; if (e !== 1'b1 || d !== 8'h0E) begin
      $display("FAIL par_rd err=%b dout=%h want 1/0e", e, d); n_err++; end
    access(MODE_DIRECT, 1'b1, 8'h21, 2'b00, 8'h00, 1'b0, lat, d, b, e);
    u_dut.u_array.r_mem[7'h21] = u_dut.u_array.r_mem[7'h21] ^ 9'h002;
    access(MODE_BIT, 1'b1, 8'h08, 2'b00, 8'h00, 1'b1, lat, d, b, e);
    n_vec++; if (e !== 1'b1 || lat !== 3) begin
      $display("FAIL par_bw err=%b lat=%0d want 1/3", e, lat); n_err++; end
    access(MODE_DIRECT, 1'b0, 8'h21, 2'b00, 8'h00, 1'b0, lat, d, b, e);
    n_vec++; if (d !== 8'h02 || e !== 1'b1) begin
      $display("FAIL par_keep dout=%h err=%b want 02/1", d, e); n_err++; end
  endtask
`endif

  initial begin
    test_reset();
    test_byte_roundtrip();
    test_bank();
    test_bit_rmw();
    test_back_to_back();
    test_illegal();
    test_reset_midop();
`ifdef DATARAM_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
